moore_seq_detector: RTL and testbench



---
 rtl/moore_seq_detector.sv | 209 ++++++++++++++++++++
 tb/tb_moore_seq_detector.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// ---------------------------------------------------------------------------
// moore_seq_detector
//
// Purpose:
//   Parametrised Moore serial-pattern detector. It watches a qualified
//   serial bit stream for a PAT_LEN-bit PATTERN. PATTERN[PAT_LEN-1] is the
//   first bit expected. Matches may overlap (OVERLAP = 1) or be
//   non-overlapping (OVERLAP = 0). State Sk means that the last k consumed
//   bits equal the first k pattern bits. The block reports a Moore match
//   flag and keeps a saturating match counter.
//
// Ports:
//   clk          in   1        clock, all logic on the rising edge
//   rst_n        in   1        synchronous active-low reset
//   clear        in   1        synchronous clear of state and counter
//   in_valid     in   1        qualifier, in_bit consumed only when high
//   in_bit       in   1        serial data bit
//   state_out    out  STATE_W  current state index k (0..PAT_LEN)
//   match        out  1        high while the state is S_PAT_LEN
//   match_count  out  CNT_W    saturating count of entries into S_PAT_LEN
//
// Optional feature:
//   Define SEQ_DET_IDLE_TIMEOUT_EN to enable a partial-match idle timeout.
//   An 8-bit counter then counts consecutive in_valid-low cycles spent in
//   S1..S_PAT_LEN-1. The state drops to S0 on the edge where the count
//   reaches IDLE_TIMEOUT. When the macro is undefined, a partial match
//   holds indefinitely.
// ---------------------------------------------------------------------------
module moore_seq_detector #(
  parameter int                 PAT_LEN      = 4,
  parameter logic [PAT_LEN-1:0] PATTERN      = 4'b1011,
  parameter bit                 OVERLAP      = 1'b1,
  parameter int                 CNT_W        = 8,
  parameter int                 IDLE_TIMEOUT = 15,
  localparam int                STATE_W      = $clog2(PAT_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic [STATE_W-1:0] state_out,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  // Catch illegal parameterisations at elaboration time.
  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("moore_seq_detector: PAT_LEN out of range 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("moore_seq_detector: CNT_W out of range 1..32");
  end
  if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_idle
    $error("moore_seq_detector: IDLE_TIMEOUT out of range 1..255");
  end

  // Only S0 and the full-match state have names. The intermediate
  // partial-match states are plain indices, reached by casting
  // fallback-table entries.
  typedef enum logic [STATE_W-1:0] {
    S0      = '0,
    S_MATCH = STATE_W'(PAT_LEN)
  } state_t;

  localparam int              N_CODES = 2 ** STATE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Elaboration-time fallback function.
  // The bit history is the matched prefix PATTERN[PAT_LEN-1 -: k] followed
  // by the new bit. The function returns the longest suffix of that history
  // (at most PAT_LEN bits) that is also a prefix of the pattern.
  // Leaving a full match without overlap restarts from an empty history.
  function automatic int calc_next(input int k, input int b);
    int   k_eff;
    int   len;
    int   best;
    int   idx;
    logic ok;
    logic hb;
    k_eff = (k == PAT_LEN && !OVERLAP) ? 0 : k;
    len   = k_eff + 1;
    best  = 0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++) begin
          idx = len - j + m;
          if (idx == k_eff) begin
            hb = (b != 0);
          end else begin
            hb = PATTERN[PAT_LEN-1-idx];
          end
          if (hb != PATTERN[PAT_LEN-1-m]) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          best = j;
        end
      end
    end
    return best;
  endfunction

  // Transition table indexed by [current state code][in_bit].
  // The table covers every state code, so unreachable codes fall back to S0.
  logic [STATE_W-1:0] trans_tab [N_CODES][2];

  for (genvar k = 0; k < N_CODES; k++) begin : g_tab_state
    for (genvar b = 0; b < 2; b++) begin : g_tab_bit
      if (k <= PAT_LEN) begin : g_live
        localparam int NXT = calc_next(k, b);
        assign trans_tab[k][b] = STATE_W'(NXT);
      end else begin : g_dead
        assign trans_tab[k][b] = '0;
      end
    end
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef SEQ_DET_IDLE_TIMEOUT_EN
  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_TIMEOUT - 1);

  logic [7:0] idle_q;
  logic [7:0] idle_d;
  logic       partial;

  assign partial = (state_q != S0) && (state_q != S_MATCH);

  // State register, match counter and idle counter.
  // The synchronous reset has the highest priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state and counter logic. Priority is clear, then a consumed bit,
  // then the idle timeout. The timeout fires on the edge where this idle
  // cycle would bring the count to IDLE_TIMEOUT. A timeout never touches
  // the match counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = '0;
    if (clear) begin
      state_d = S0;
      cnt_d   = '0;
    end else if (in_valid) begin
      state_d = state_t'(trans_tab[state_q][in_bit]);
      if (state_d == S_MATCH && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (partial) begin
      if (idle_q == IDLE_LIMIT) begin
        state_d = S0;
      end else begin
        idle_d = idle_q + 8'd1;
      end
    end
  end
`else
  // State register and match counter.
  // The synchronous reset has the highest priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic. Clear beats a consumed bit.
  // With no valid bit, everything holds.
  // The counter advances on every entry into S_MATCH, including
  // S_MATCH -> S_MATCH, and sticks at its maximum value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = S0;
      cnt_d   = '0;
    end else if (in_valid) begin
      state_d = state_t'(trans_tab[state_q][in_bit]);
      if (state_d == S_MATCH && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
`endif

  assign state_out   = state_q;
  assign match       = (state_q == S_MATCH);
  assign match_count = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detector
//
// Purpose:
//   Self-checking bench for moore_seq_detector. Three instances share one
//   input stream:
//     u_ov  : default parameters (overlapping)
//     u_nov : OVERLAP = 0
//     u_sat : CNT_W = 2 (saturation)
//   The expected behaviour comes from a history-window model. For every
//   instance, the model keeps the recent consumed bits in a queue and takes
//   the state as the longest suffix that is also a pattern prefix.
// ---------------------------------------------------------------------------
module tb_moore_seq_detector;

  localparam int         PAT_LEN = 4;
  localparam logic [3:0] PAT     = 4'b1011;
  localparam int         SW      = 3;
  localparam int         IDLE_TO = 15;

  logic clk;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic in_bit;

  logic [SW-1:0] st_ov, st_nov, st_sat;
  logic          m_ov, m_nov, m_sat;
  logic [7:0]    c_ov, c_nov;
  logic [1:0]    c_sat;

  moore_seq_detector u_ov (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .state_out(st_ov), .match(m_ov), .match_count(c_ov)
  );

  moore_seq_detector #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .state_out(st_nov), .match(m_nov), .match_count(c_nov)
  );

  moore_seq_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .state_out(st_sat), .match(m_sat), .match_count(c_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference model state, one entry per instance.
  bit hist [3][$];
  int m_state [3];
  int m_cnt [3];
  int m_idle [3];
  int ov_cfg [3]   = '{1, 0, 1};
  int cnt_max [3]  = '{255, 255, 3};

  // Longest suffix of the history window (at most PAT_LEN bits) that
  // equals a prefix of the pattern.
  function automatic int bestPrefix(input int i);
    int         n;
    logic [3:0] p;
    bit         ok;
    p = PAT;
    n = hist[i].size();
    for (int j = (n < PAT_LEN ? n : PAT_LEN); j >= 1; j--) begin
      ok = 1'b1;
      for (int m = 0; m < j; m++) begin
        if (hist[i][n-j+m] != p[PAT_LEN-1-m]) ok = 1'b0;
      end
      if (ok) return j;
    end
    return 0;
  endfunction

  task automatic modelStep(input bit v, input bit b, input bit clr, input bit rstn);
    for (int i = 0; i < 3; i++) begin
      if (!rstn || clr) begin
        hist[i].delete();
        m_state[i] = 0;
        m_cnt[i]   = 0;
        m_idle[i]  = 0;
      end else if (v) begin
        if (m_state[i] == PAT_LEN && ov_cfg[i] == 0) hist[i].delete();
        hist[i].push_back(b);
        while (hist[i].size() > PAT_LEN) void'(hist[i].pop_front());
        m_state[i] = bestPrefix(i);
        if (m_state[i] == PAT_LEN && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        m_idle[i] = 0;
      end else begin
`ifdef SEQ_DET_IDLE_TIMEOUT_EN
        if (m_state[i] > 0 && m_state[i] < PAT_LEN) begin
          m_idle[i]++;
          if (m_idle[i] == IDLE_TO) begin
            hist[i].delete();
            m_state[i] = 0;
            m_idle[i]  = 0;
          end
        end else begin
          m_idle[i] = 0;
        end
`else
        m_idle[i] = 0;
`endif
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("ov.state",  32'(st_ov),  32'(m_state[0]));
    check("ov.match",  32'(m_ov),   32'(m_state[0] == PAT_LEN));
    check("ov.count",  32'(c_ov),   32'(m_cnt[0]));
    check("nov.state", 32'(st_nov), 32'(m_state[1]));
    check("nov.match", 32'(m_nov),  32'(m_state[1] == PAT_LEN));
    check("nov.count", 32'(c_nov),  32'(m_cnt[1]));
    check("sat.state", 32'(st_sat), 32'(m_state[2]));
    check("sat.match", 32'(m_sat),  32'(m_state[2] == PAT_LEN));
    check("sat.count", 32'(c_sat),  32'(m_cnt[2]));
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, then
  // sample the outputs 1 time unit after the edge.
  task automatic applyStimulus(input bit v, input bit b, input bit clr, input bit rstn);
    in_valid = v;
    in_bit   = b;
    clear    = clr;
    rst_n    = rstn;
    @(posedge clk);
    modelStep(v, b, clr, rstn);
    #1;
    checkOutput();
  endtask

  int  exp_ov  [7] = '{1, 2, 3, 4, 2, 3, 4};
  int  exp_nov [7] = '{1, 2, 3, 4, 0, 1, 1};
  bit  seq7    [7] = '{1, 0, 1, 1, 0, 1, 1};
  bit  sat_seq [16] = '{1,0,1,1, 0,1,1, 0,1,1, 0,1,1, 0,1,1};
  int  r;
  bit  rv, rb, rc, rr;

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;

    // Reset for two cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("reset.count", 32'(c_ov), 32'd0);

    // Directed overlap / non-overlap sequence 1011011
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, seq7[i], 1'b0, 1'b1);
      check("seq.ov_state",  32'(st_ov),  32'(exp_ov[i]));
      check("seq.nov_state", 32'(st_nov), 32'(exp_nov[i]));
    end
    check("seq.ov_count",  32'(c_ov),  32'd2);
    check("seq.nov_count", 32'(c_nov), 32'd1);

    // Gapped input: 1,0, five idle cycles, 1,1
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

    // Saturation with five overlapping matches, then a clear
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, sat_seq[i], 1'b0, 1'b1);
    check("sat.saturated", 32'(c_sat), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Clear on the same edge as the final pattern bit
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    check("prio.clear_match", 32'(m_ov), 32'd0);

    // Reset from S3 with clear low
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("prio.reset_state", 32'(st_ov), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      r  = int'($urandom_range(99));
      rr = (r >= 2);
      rc = (r >= 2 && r < 5);
      rv = ($urandom_range(99) < 75);
      rb = 1'($urandom);
      applyStimulus(rv, rb, rc, rr);
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
